// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, 8 data bits LSB first, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to insert the even-parity bit between the data bits and the stop bit.
module uart_tx_framer #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx_serial,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int unsigned CNT_W  = 16;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned IDX_W  = 3;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      S_PARITY = 3'd4,
`endif
      S_STOP   = 3'd3
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic                serial_q, serial_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                bit_end;
`ifdef UART_TX_PARITY_EN
   logic                parity_q, parity_d;
`endif

   // State register; reset parks the line at idle-high and aborts any frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         shift_q  <= '0;
         serial_q <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         serial_q <= serial_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   // Next-state logic; serial_d is the level of the bit that starts on the coming edge.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      serial_d = serial_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      bit_end  = (cnt_q == CNT_LAST);

      if (state_q != S_IDLE) begin
         cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (tx_start) begin
               state_d  = S_START;
               cnt_d    = '0;
               idx_d    = '0;
               shift_d  = tx_data;
               serial_d = 1'b0;
               busy_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
               parity_d = ^tx_data;
`endif
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d  = S_DATA;
               serial_d = shift_q[0];
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                  state_d  = S_PARITY;
                  serial_d = parity_q;
`else
                  state_d  = S_STOP;
                  serial_d = 1'b1;
`endif
               end else begin
                  idx_d    = idx_q + IDX_W'(1);
                  shift_d  = {1'b0, shift_q[DATA_W-1:1]};
                  serial_d = shift_q[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               state_d  = S_STOP;
               serial_d = 1'b1;
            end
         end
`endif
         S_STOP: begin
            if (bit_end) begin
               state_d  = S_IDLE;
               serial_d = 1'b1;
               busy_d   = 1'b0;
               done_d   = 1'b1;
            end
         end
         default: begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            serial_d = 1'b1;
            busy_d   = 1'b0;
         end
      endcase
   end

   assign tx_serial = serial_q;
   assign tx_busy   = busy_q;
   assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed self-checking bench for uart_tx_framer at CLKS_PER_BIT=4.
module tb_uart_tx_framer;

   localparam int unsigned N = 4;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned NBITS = 11;
`else
   localparam int unsigned NBITS = 10;
`endif
   localparam int unsigned FRAME = NBITS * N;

   logic       clk = 1'b0;
   logic       reset;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_serial;
   logic       tx_busy;
   logic       tx_done;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int done_a, done_b;

   uart_tx_framer #(.CLKS_PER_BIT(N)) dut (
      .clk      (clk),
      .reset    (reset),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_serial(tx_serial),
      .tx_busy  (tx_busy),
      .tx_done  (tx_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Line levels in transmission order: start, d[0]..d[7], [parity], stop.
   function automatic logic [10:0] frame_of(input logic [7:0] d);
      logic [10:0] f;
      f      = '1;
      f[0]   = 1'b0;
      f[8:1] = d;
`ifdef UART_TX_PARITY_EN
      f[9]   = ^d;
`endif
      return f;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Accept one frame and check every cycle; optional mid-frame start pulse and data change.
   task automatic run_frame(input string tag, input logic [7:0] d, input bit hold,
                            input int inj_cyc, input logic [7:0] inj_d,
                            input int chg_cyc, input logic [7:0] chg_d,
                            output int done_at);
      logic [10:0] exp;
      exp      = frame_of(d);
      tx_data  = d;
      tx_start = 1'b1;
      step();
      if (!hold) tx_start = 1'b0;
      for (int c = 0; c < int'(FRAME); c++) begin
         check({tag, "_serial"}, 32'(tx_serial), 32'(exp[c / int'(N)]));
         check({tag, "_busy"},   32'(tx_busy),   32'd1);
         check({tag, "_done"},   32'(tx_done),   32'd0);
         if (c == inj_cyc) begin
            tx_start = 1'b1;
            tx_data  = inj_d;
         end else if (c == inj_cyc + 1 && !hold) begin
            tx_start = 1'b0;
         end
         if (c == chg_cyc) tx_data = chg_d;
         step();
      end
      check({tag, "_done_end"},   32'(tx_done),   32'd1);
      check({tag, "_busy_end"},   32'(tx_busy),   32'd0);
      check({tag, "_serial_end"}, 32'(tx_serial), 32'd1);
      done_at = cyc;
   endtask

   task automatic check_idle(input string tag, input int cycles);
      for (int c = 0; c < cycles; c++) begin
         step();
         check({tag, "_idle_serial"}, 32'(tx_serial), 32'd1);
         check({tag, "_idle_busy"},   32'(tx_busy),   32'd0);
         check({tag, "_idle_done"},   32'(tx_done),   32'd0);
      end
   endtask

   initial begin
      reset    = 1'b0;
      tx_start = 1'b0;
      tx_data  = 8'h00;
      #12;
      check("rst_serial", 32'(tx_serial), 32'd1);
      check("rst_busy",   32'(tx_busy),   32'd0);
      check("rst_done",   32'(tx_done),   32'd0);
      #10 reset = 1'b1;
      check_idle("post_rst", 2);

      // Basic frames: 0xA5 and 0x07 (parity 0 and 1 when enabled).
      run_frame("a5", 8'hA5, 1'b0, -10, 8'h00, -10, 8'h00, done_a);
      check_idle("a5", 2);
      run_frame("x07", 8'h07, 1'b0, -10, 8'h00, -10, 8'h00, done_a);
      check_idle("x07", 2);

      // Request during busy is ignored and not queued.
      run_frame("ign", 8'h3C, 1'b0, 12, 8'hFF, -10, 8'h00, done_a);
      check_idle("ign", int'(FRAME) + 2);

      // Data change after acceptance does not alter the frame.
      run_frame("chg", 8'h0F, 1'b0, -10, 8'h00, 0, 8'hF0, done_a);
      check_idle("chg", 2);

      // Held tx_start: back-to-back frames with a single idle cycle between them.
      run_frame("b2b1", 8'h55, 1'b1, -10, 8'h00, 0, 8'hAA, done_a);
      run_frame("b2b2", 8'hAA, 1'b0, -10, 8'h00, -10, 8'h00, done_b);
      check("b2b_spacing", 32'(done_b - done_a), 32'(FRAME + 1));
      check_idle("b2b", 2);

      // Asynchronous reset mid-frame aborts without tx_done.
      tx_data  = 8'h81;
      tx_start = 1'b1;
      step();
      tx_start = 1'b0;
      for (int c = 0; c < 17; c++) step();
      check("abort_busy_before", 32'(tx_busy), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("abort_serial", 32'(tx_serial), 32'd1);
      check("abort_busy",   32'(tx_busy),   32'd0);
      check("abort_done",   32'(tx_done),   32'd0);
      step();
      check("abort_hold_done", 32'(tx_done), 32'd0);
      #2 reset = 1'b1;
      check_idle("abort", 2);
      run_frame("x81", 8'h81, 1'b0, -10, 8'h00, -10, 8'h00, done_a);
      check_idle("x81", 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
